// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control unit: opcodes, state encoding and
// the control-word layout that the datapath decodes.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MVA = 4'b0001;
    localparam logic [3:0] OP_MVB = 4'b0010;
    localparam logic [3:0] OP_LDA = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_ADD = 4'b0111;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_E0   = 3'd3,
        ST_E1   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    // One bit per control line, MSB first in this order.
    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_in;
        logic ram_read;
        logic ram_write;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic halted;
    } ctrl_t;

    localparam int CTRL_W = 13;

    // True for every opcode the sequencer defines.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_MVA, OP_MVB, OP_LDA,
            OP_STA, OP_JMP, OP_ADD, OP_HLT: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for opcodes that need a second execute cycle.
    function automatic logic op_has_e1(input logic [3:0] op);
        logic two;
        case (op)
            OP_LDA, OP_STA: two = 1'b1;
            default:        two = 1'b0;
        endcase
        return two;
    endfunction

    // Number of bus drivers enabled in a control word (must never exceed 1).
    function automatic logic [2:0] bus_driver_count(input ctrl_t c);
        return {2'b00, c.pc_out} + {2'b00, c.ram_read} + {2'b00, c.ir_out}
             + {2'b00, c.a_out} + {2'b00, c.alu_out};
    endfunction

endpackage

// File: rtl/sap_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit SAP processor. Control lines
// are a combinational decode of the registered state and the IR opcode, so an
// asynchronous reset drops them in the same cycle.
module sap_control_unit
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_read,
    output logic       ram_write,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       halted,
    output logic       illegal_op
);

    state_e state_r;
    state_e state_nxt_s;
    logic   illegal_r;
    ctrl_t  ctrl_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sticky flag: an undefined opcode reached its execute cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if ((state_r == ST_E0) && !op_is_legal(opcode)) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next-state logic; run is only consulted in IDLE and at instruction end.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) state_nxt_s = ST_F0;
                else     state_nxt_s = ST_IDLE;
            end
            ST_F0: state_nxt_s = ST_F1;
            ST_F1: state_nxt_s = ST_E0;
            ST_E0: begin
                if (opcode == OP_HLT)      state_nxt_s = ST_HALT;
                else if (op_has_e1(opcode)) state_nxt_s = ST_E1;
                else if (run)              state_nxt_s = ST_F0;
                else                       state_nxt_s = ST_IDLE;
            end
            ST_E1: begin
                if (run) state_nxt_s = ST_F0;
                else     state_nxt_s = ST_IDLE;
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control-word decode; each state enables at most one bus driver.
    always_comb begin
        ctrl_s = ctrl_t'({CTRL_W{1'b0}});
        case (state_r)
            ST_F0: begin
                ctrl_s.pc_out = 1'b1;
                ctrl_s.mar_in = 1'b1;
            end
            ST_F1: begin
                ctrl_s.ram_read = 1'b1;
                ctrl_s.ir_in    = 1'b1;
                ctrl_s.pc_inc   = 1'b1;
            end
            ST_E0: begin
                case (opcode)
                    OP_MVA: begin
                        ctrl_s.ir_out = 1'b1;
                        ctrl_s.a_in   = 1'b1;
                    end
                    OP_MVB: begin
                        ctrl_s.ir_out = 1'b1;
                        ctrl_s.b_in   = 1'b1;
                    end
                    OP_LDA, OP_STA: begin
                        ctrl_s.ir_out = 1'b1;
                        ctrl_s.mar_in = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_s.ir_out  = 1'b1;
                        ctrl_s.pc_load = 1'b1;
                    end
                    OP_ADD: begin
                        ctrl_s.alu_out = 1'b1;
                        ctrl_s.a_in    = 1'b1;
                    end
                    default: ctrl_s = ctrl_t'({CTRL_W{1'b0}});
                endcase
            end
            ST_E1: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl_s.ram_read = 1'b1;
                        ctrl_s.a_in     = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_s.a_out     = 1'b1;
                        ctrl_s.ram_write = 1'b1;
                    end
                    default: ctrl_s = ctrl_t'({CTRL_W{1'b0}});
                endcase
            end
            ST_HALT: ctrl_s.halted = 1'b1;
            default: ctrl_s = ctrl_t'({CTRL_W{1'b0}});
        endcase
    end

    assign pc_out     = ctrl_s.pc_out;
    assign pc_inc     = ctrl_s.pc_inc;
    assign pc_load    = ctrl_s.pc_load;
    assign mar_in     = ctrl_s.mar_in;
    assign ram_read   = ctrl_s.ram_read;
    assign ram_write  = ctrl_s.ram_write;
    assign ir_in      = ctrl_s.ir_in;
    assign ir_out     = ctrl_s.ir_out;
    assign a_in       = ctrl_s.a_in;
    assign a_out      = ctrl_s.a_out;
    assign b_in       = ctrl_s.b_in;
    assign alu_out    = ctrl_s.alu_out;
    assign halted     = ctrl_s.halted;
    assign illegal_op = illegal_r;

endmodule
